cache_wb: RTL

- Parametrised direct-mapped, write-back data cache with byte-lane writes.
- Sits between the core's load/store port and the burst memory controller.
- Generalises the previous 4-column write-on-request cache: configurable column count, dirty tracking, line fill on miss, eviction of dirty lines, post-reset tag sweep, and request/ready handshakes on both sides.

---
 rtl/cache_wb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cache_wb.sv
// rtl/cache_wb.sv - direct-mapped write-back data cache with byte-lane writes and burst line fill/evict
`timescale 1ns/1ps
module cache_wb #(
    parameter int LINE_IX_BITWIDTH   = 8,
    parameter int COLUMN_IX_BITWIDTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic        enable,
    input  logic [3:0]  write_enable,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_out_ready,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_address,
    input  logic        mem_ack,
    output logic [31:0] mem_wdata,
    input  logic        mem_wready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);
    localparam int LINE_COUNT      = 2 ** LINE_IX_BITWIDTH;
    localparam int WORDS_PER_LINE  = 2 ** COLUMN_IX_BITWIDTH;
    localparam int TAG_BITWIDTH    = 32 - LINE_IX_BITWIDTH - COLUMN_IX_BITWIDTH - 2;
    localparam int ENTRY_BITWIDTH  = TAG_BITWIDTH + 2;
    localparam int OFFSET_BITWIDTH = COLUMN_IX_BITWIDTH + 2;
    localparam logic [COLUMN_IX_BITWIDTH:0] LAST_COL = {1'b0, {COLUMN_IX_BITWIDTH{1'b1}}};

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_RETRY
    } state_t;

    state_t state;

    logic [COLUMN_IX_BITWIDTH-1:0] col;
    logic [LINE_IX_BITWIDTH-1:0]   line;
    logic [TAG_BITWIDTH-1:0]       tag;
    logic                          unused_byte_offset;

    assign col  = address[OFFSET_BITWIDTH-1:2];
    assign line = address[OFFSET_BITWIDTH +: LINE_IX_BITWIDTH];
    assign tag  = address[31 -: TAG_BITWIDTH];
    assign unused_byte_offset = ^address[1:0];

    // Tag entry layout: {dirty, valid, tag}
    logic [ENTRY_BITWIDTH-1:0] tag_ram [LINE_COUNT];
    logic [31:0]               data_ram [WORDS_PER_LINE][LINE_COUNT];
    logic [ENTRY_BITWIDTH-1:0] rd_entry;
    logic [31:0]               rd_words [WORDS_PER_LINE];
    logic                      rd_dirty, rd_valid;
    logic [TAG_BITWIDTH-1:0]   rd_tag;

    assign {rd_dirty, rd_valid, rd_tag} = rd_entry;

    logic [LINE_IX_BITWIDTH-1:0]   init_cnt;
    logic [COLUMN_IX_BITWIDTH:0]   c;
    logic                          hit, beat_ok, wr_beat, rd_beat, last_beat, lookup_write, rd_en;
    logic [31:0]                   merged;

    assign hit          = rd_valid && (rd_tag == tag);
    assign beat_ok      = !mem_req || mem_ack;
    assign wr_beat      = (state == S_EVICT) && mem_wready && beat_ok;
    assign rd_beat      = (state == S_FILL) && mem_rvalid && beat_ok;
    assign last_beat    = (c == LAST_COL);
    assign lookup_write = (state == S_LOOKUP) && hit && enable && (|write_enable);
    assign rd_en        = ((state == S_IDLE) && enable && !data_out_ready) || (state == S_RETRY);
    assign mem_wdata    = rd_words[c[COLUMN_IX_BITWIDTH-1:0]];

    always_comb begin
        merged = rd_words[col];
        for (int i = 0; i < 4; i++) begin
            if (write_enable[i]) merged[8*i +: 8] = data_in[8*i +: 8];
        end
    end

    logic                          tag_we, data_we;
    logic [LINE_IX_BITWIDTH-1:0]   tag_wa;
    logic [ENTRY_BITWIDTH-1:0]     tag_wd;
    logic [COLUMN_IX_BITWIDTH-1:0] data_wcol;
    logic [31:0]                   data_wd;

    always_comb begin
        tag_we    = 1'b0;
        tag_wa    = line;
        tag_wd    = '0;
        data_we   = 1'b0;
        data_wcol = col;
        data_wd   = merged;
        if (rst_n) begin
            case (state)
                S_INIT: begin
                    tag_we = 1'b1;
                    tag_wa = init_cnt;
                end
                S_LOOKUP: begin
                    tag_we  = lookup_write;
                    tag_wd  = {2'b11, tag};
                    data_we = lookup_write;
                end
                S_FILL: begin
                    tag_we    = rd_beat && last_beat;
                    tag_wd    = {2'b01, tag};
                    data_we   = rd_beat;
                    data_wcol = c[COLUMN_IX_BITWIDTH-1:0];
                    data_wd   = mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // All columns of a line are read together, so an eviction streams straight from rd_words
    always_ff @(posedge clk) begin
        if (tag_we) tag_ram[tag_wa] <= tag_wd;
        if (data_we) data_ram[data_wcol][line] <= data_wd;
        if (rd_en) begin
            rd_entry <= tag_ram[line];
            for (int k = 0; k < WORDS_PER_LINE; k++) rd_words[k] <= data_ram[k][line];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_INIT;
            init_cnt       <= '0;
            c              <= '0;
            data_out       <= '0;
            data_out_ready <= 1'b0;
            busy           <= 1'b1;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_address    <= '0;
        end else begin
            data_out_ready <= 1'b0;
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (enable && !data_out_ready) state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (hit) begin
                        state <= S_IDLE;
                        if (enable) begin
                            data_out_ready <= 1'b1;
                            data_out       <= merged;
                        end
                    end else begin
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        c       <= '0;
                        if (rd_valid && rd_dirty) begin
                            state       <= S_EVICT;
                            mem_we      <= 1'b1;
                            mem_address <= {rd_tag, line, {OFFSET_BITWIDTH{1'b0}}};
                        end else begin
                            state       <= S_FILL;
                            mem_we      <= 1'b0;
                            mem_address <= {tag, line, {OFFSET_BITWIDTH{1'b0}}};
                        end
                    end
                end
                S_EVICT: begin
                    if (mem_ack) mem_req <= 1'b0;
                    if (wr_beat) begin
                        c <= c + 1'b1;
                        if (last_beat) begin
                            state       <= S_FILL;
                            c           <= '0;
                            mem_req     <= 1'b1;
                            mem_we      <= 1'b0;
                            mem_address <= {tag, line, {OFFSET_BITWIDTH{1'b0}}};
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) mem_req <= 1'b0;
                    if (rd_beat) begin
                        c <= c + 1'b1;
                        if (last_beat) begin
                            state <= S_RETRY;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_RETRY: state <= S_LOOKUP;
                default: state <= S_INIT;
            endcase
        end
    end
endmodule
